// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arb_pkg;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_e;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts data grants made while fetch waits and raises a force-fetch flag at STARVE_MAX.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic if_gnt_i,
  input  logic d_gnt_i,
  output logic force_if_o
);

  localparam logic [STARVE_W-1:0] Limit = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_cnt;
  logic [STARVE_W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (!if_req_i || if_gnt_i) begin
      w_cnt_d = '0;
    end else if (d_gnt_i && (r_cnt != '1)) begin
      w_cnt_d = r_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign force_if_o = if_req_i && d_req_i && (r_cnt == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory between fetch and data requesters; data has priority.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MEM_LAT - 1);

  arb_state_e       r_state, w_state_d;
  arb_owner_e       r_owner, w_owner_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;

  logic w_resp, w_free, w_force_if, w_d_win, w_if_win, w_rd_gnt;

  assign w_resp = (r_state == ARB_WAIT) && (r_cnt == LastCnt);
  assign w_free = (r_state == ARB_IDLE) || w_resp;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .if_req_i  (if_req_i),
    .d_req_i   (d_req_i),
    .if_gnt_i  (w_if_win),
    .d_gnt_i   (w_d_win),
    .force_if_o(w_force_if)
  );
`else
  assign w_force_if = 1'b0;
`endif

  // Grants are gated by rst so every output is 0 while reset is held.
  assign w_d_win  = rst && w_free && d_req_i && !w_force_if;
  assign w_if_win = rst && w_free && if_req_i && !w_d_win;
  assign w_rd_gnt = w_if_win || (w_d_win && !d_we_i);

  always_comb begin
    w_state_d = ARB_IDLE;
    w_owner_d = r_owner;
    w_cnt_d   = '0;
    if (!w_free) begin
      w_state_d = ARB_WAIT;
      w_cnt_d   = r_cnt + CNT_W'(1);
    end else if (w_rd_gnt) begin
      w_state_d = ARB_WAIT;
      w_owner_d = w_d_win ? OWN_D : OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_IF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = w_rd_gnt;
    mem_write_en_o = w_d_win && d_we_i;
    if (w_d_win) begin
      mem_addr_o = d_addr_i;
      if (d_we_i) begin
        mem_data_o = d_wdata_i;
      end
    end else if (w_if_win) begin
      mem_addr_o = if_addr_i;
    end
  end

  assign if_gnt_o    = w_if_win;
  assign d_gnt_o     = w_d_win;
  assign if_rvalid_o = rst && w_resp && (r_owner == OWN_IF);
  assign d_rvalid_o  = rst && w_resp && (r_owner == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? mem_data_i : '0;
  assign d_rdata_o   = d_rvalid_o ? mem_data_i : '0;
  assign busy_o      = rst && (r_state == ARB_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 (a_*), one with MEM_LAT=3 (b_*).
module tb_mem_arbiter;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_re, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_data;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_re, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(a_d_gnt), .d_rvalid_o(a_d_rvalid), .d_rdata_o(a_d_rdata),
    .mem_addr_o(a_mem_addr), .mem_data_o(a_mem_data),
    .mem_read_en_o(a_mem_re), .mem_write_en_o(a_mem_we),
    .mem_data_i(mem_rdata), .busy_o(a_busy)
  );

  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(b_d_gnt), .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata),
    .mem_addr_o(b_mem_addr), .mem_data_o(b_mem_data),
    .mem_read_en_o(b_mem_re), .mem_write_en_o(b_mem_we),
    .mem_data_i(mem_rdata), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0100_0000; d_addr = 32'h0100_0100; d_wdata = 32'h1234_5678;
    mem_rdata = 32'hA5A5_A5A5;

    // Reset held with both requests high: everything quiet.
    cycle(); #1;
    chk("rst_if_gnt", a_if_gnt, 0);     chk("rst_d_gnt", a_d_gnt, 0);
    chk("rst_mem_re", a_mem_re, 0);     chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_if_rvalid", a_if_rvalid, 0); chk("rst_busy", a_busy, 0);
    chk("rst_b_d_gnt", b_d_gnt, 0);     chk("rst_b_mem_re", b_mem_re, 0);

    // Fetch read, MEM_LAT=1.
    cycle(); rst = 1'b1; d_req = 1'b0; if_addr = 32'h0100_0000; mem_rdata = 32'h1111_1111; #1;
    chk("f_if_gnt", a_if_gnt, 1); chk("f_mem_addr", a_mem_addr, 32'h0100_0000);
    chk("f_mem_re", a_mem_re, 1);
    cycle(); if_req = 1'b0; #1;
    chk("f_if_rvalid", a_if_rvalid, 1); chk("f_if_rdata", a_if_rdata, 32'h1111_1111);
    chk("f_busy", a_busy, 1);           chk("f_if_gnt_resp", a_if_gnt, 0);

    // Contention: data read beats fetch.
    pulse_reset();
    cycle(); if_req = 1'b1; if_addr = 32'h0100_0004; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0100_0100; #1;
    chk("c_d_gnt", a_d_gnt, 1); chk("c_if_gnt0", a_if_gnt, 0);
    chk("c_mem_addr0", a_mem_addr, 32'h0100_0100);
    cycle(); d_req = 1'b0; mem_rdata = 32'h2222_2222; #1;
    chk("c_d_rvalid", a_d_rvalid, 1); chk("c_d_rdata", a_d_rdata, 32'h2222_2222);
    chk("c_if_gnt1", a_if_gnt, 1);    chk("c_mem_addr1", a_mem_addr, 32'h0100_0004);
    chk("c_if_rvalid1", a_if_rvalid, 0);
    cycle(); if_req = 1'b0; mem_rdata = 32'h3333_3333; #1;
    chk("c_if_rvalid2", a_if_rvalid, 1); chk("c_if_rdata2", a_if_rdata, 32'h3333_3333);
    chk("c_d_rvalid2", a_d_rvalid, 0);   chk("c_d_rdata2", a_d_rdata, 0);

    // Write with fetch pending.
    pulse_reset();
    cycle(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0200; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h0100_0008; #1;
    chk("w_d_gnt", a_d_gnt, 1);  chk("w_mem_we", a_mem_we, 1); chk("w_mem_re", a_mem_re, 0);
    chk("w_mem_data", a_mem_data, 32'hDEAD_BEEF); chk("w_mem_addr", a_mem_addr, 32'h0100_0200);
    cycle(); d_req = 1'b0; d_we = 1'b0; #1;
    chk("w_if_gnt", a_if_gnt, 1); chk("w_d_rvalid", a_d_rvalid, 0);
    chk("w_mem_we_off", a_mem_we, 0);
    cycle(); if_req = 1'b0; #1;
    chk("w_if_rvalid", a_if_rvalid, 1); chk("w_d_rvalid2", a_d_rvalid, 0);

    // Blocking, MEM_LAT=3.
    pulse_reset();
    cycle(); if_req = 1'b1; if_addr = 32'h0100_0010; #1;
    chk("b_if_gnt", b_if_gnt, 1); chk("b_busy0", b_busy, 0);
    cycle(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0300; #1;
    chk("b_busy1", b_busy, 1); chk("b_d_gnt1", b_d_gnt, 0); chk("b_mem_re1", b_mem_re, 0);
    cycle(); #1;
    chk("b_busy2", b_busy, 1); chk("b_d_gnt2", b_d_gnt, 0); chk("b_if_rvalid2", b_if_rvalid, 0);
    cycle(); mem_rdata = 32'h4444_4444; #1;
    chk("b_d_gnt3", b_d_gnt, 1); chk("b_if_rvalid3", b_if_rvalid, 1);
    chk("b_if_rdata3", b_if_rdata, 32'h4444_4444); chk("b_mem_addr3", b_mem_addr, 32'h0100_0300);
    cycle(); d_req = 1'b0; #1;
    chk("b_d_rvalid4", b_d_rvalid, 0); chk("b_busy4", b_busy, 1);
    cycle(); #1;
    chk("b_d_rvalid5", b_d_rvalid, 0);
    cycle(); mem_rdata = 32'h5555_5555; #1;
    chk("b_d_rvalid6", b_d_rvalid, 1); chk("b_d_rdata6", b_d_rdata, 32'h5555_5555);

    // Starvation: data writes held against a waiting fetch.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(); d_req = 1'b1; d_we = 1'b1; if_req = 1'b1; #1;
      chk($sformatf("s_if_gnt%0d", i), a_if_gnt, (Guard && i == 4) ? 1 : 0);
      chk($sformatf("s_d_gnt%0d", i), a_d_gnt, (Guard && i == 4) ? 0 : 1);
    end
    cycle(); d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;

    // Reset during an outstanding MEM_LAT=3 read.
    pulse_reset();
    cycle(); if_req = 1'b1; if_addr = 32'h0100_0020; #1;
    chk("m_if_gnt", b_if_gnt, 1);
    cycle(); if_req = 1'b0; rst = 1'b0; #1;
    chk("m_busy_rst", b_busy, 0); chk("m_rvalid_rst", b_if_rvalid, 0);
    cycle(); rst = 1'b1; #1;
    chk("m_busy_rel", b_busy, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(); #1;
      chk($sformatf("m_if_rvalid%0d", i), b_if_rvalid, 0);
      chk($sformatf("m_busy%0d", i), b_busy, 0);
    end
    cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0400; #1;
    chk("m_d_gnt", b_d_gnt, 1); chk("m_mem_addr", b_mem_addr, 32'h0100_0400);
    cycle(); d_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
